// File: rtl/status_code_gen.sv
// rtl/status_code_gen.sv - game status encoder: edge-detected control pulses to {state, blink indicator} code plus saturating win counter
// Optional blink generator built only when STATUS_CODE_BLINK_EN is defined; otherwise the indicator is steady in WIN/LOSE.
module status_code_gen #(
  parameter int BLINK_DIV = 25_000_000,
  parameter int WIN_W     = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             win_i,
  input  logic             lose_i,
  input  logic             clear_i,
  output logic [2:0]       code_o,
  output logic [WIN_W-1:0] win_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    WIN  = 2'b10,
    LOSE = 2'b11
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIN_W-1:0] win_cnt;
  logic             cnt_inc;
  logic             state_chg;
  logic             ind;

  logic start_prev;
  logic win_prev;
  logic lose_prev;
  logic clear_prev;

  logic ev_start;
  logic ev_win;
  logic ev_lose;
  logic ev_clear;

  logic act_start;
  logic act_win;
  logic act_lose;
  logic act_clear;

  // Prev registers reset high so a level already asserted at reset release never fires.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      start_prev <= 1'b1;
      win_prev   <= 1'b1;
      lose_prev  <= 1'b1;
      clear_prev <= 1'b1;
    end else begin
      start_prev <= start_i;
      win_prev   <= win_i;
      lose_prev  <= lose_i;
      clear_prev <= clear_i;
    end
  end

  assign ev_start = start_i & ~start_prev;
  assign ev_win   = win_i   & ~win_prev;
  assign ev_lose  = lose_i  & ~lose_prev;
  assign ev_clear = clear_i & ~clear_prev;

  // Fixed priority clear > lose > win > start; losers are simply dropped.
  assign act_clear = ev_clear;
  assign act_lose  = ev_lose  & ~ev_clear;
  assign act_win   = ev_win   & ~ev_lose & ~ev_clear;
  assign act_start = ev_start & ~ev_win  & ~ev_lose & ~ev_clear;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_inc   = 1'b0;
    if (act_clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (act_start) state_nxt = RUN;
        end
        RUN: begin
          if (act_lose) begin
            state_nxt = LOSE;
          end else if (act_win) begin
            state_nxt = WIN;
            cnt_inc   = 1'b1;
          end
        end
        WIN, LOSE: begin
          if (act_start) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign state_chg = (state_nxt != state);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      win_cnt <= '0;
    end else if (act_clear) begin
      win_cnt <= '0;
    end else if (cnt_inc && (win_cnt != {WIN_W{1'b1}})) begin
      win_cnt <= win_cnt + WIN_W'(1);
    end
  end

`ifdef STATUS_CODE_BLINK_EN
  localparam int PW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] DIV_MAX = PW'(BLINK_DIV - 1);

  logic [PW-1:0] presc;
  logic          phase;

  // Restart on every state change so each blink sequence opens with a full on-period.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      presc <= '0;
      phase <= 1'b0;
    end else if (state_chg || !state[1]) begin
      presc <= '0;
      phase <= 1'b0;
    end else if (presc == DIV_MAX) begin
      presc <= '0;
      phase <= ~phase;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign ind = state[1] ? ~phase : (state == RUN);
`else
  assign ind = state[1] | (state == RUN);
`endif

  assign code_o    = {state, ind};
  assign win_cnt_o = win_cnt;

endmodule

// File: tb/tb_status_code_gen.sv
// tb/tb_status_code_gen.sv - directed vector bench for status_code_gen (BLINK_DIV=4, WIN_W=4)
module tb_status_code_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, win, lose, clear;
  logic [2:0] code;
  logic [3:0] win_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       s;
    logic       w;
    logic       l;
    logic       c;
    logic [2:0] code;
    logic [3:0] cnt;
    string      name;
  } vec_t;

  vec_t vecs[$];

  status_code_gen #(.BLINK_DIV(4), .WIN_W(4)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .start_i  (start),
    .win_i    (win),
    .lose_i   (lose),
    .clear_i  (clear),
    .code_o   (code),
    .win_cnt_o(win_cnt)
  );

  always #5 clk = ~clk;

  task automatic add(input logic s, input logic w, input logic l, input logic c,
                     input logic [2:0] cd, input logic [3:0] cn, input string nm);
    vec_t v;
    v.s = s; v.w = w; v.l = l; v.c = c; v.code = cd; v.cnt = cn; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic s, input logic w, input logic l, input logic c);
    start = s; win = w; lose = l; clear = c;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [2:0] cd, input logic [3:0] cn);
    checks++;
    if (code !== cd) begin
      failures++;
      $display("FAIL %s code: got %b want %b", nm, code, cd);
    end
    checks++;
    if (win_cnt !== cn) begin
      failures++;
      $display("FAIL %s win_cnt: got %0d want %0d", nm, win_cnt, cn);
    end
  endtask

  function automatic logic blink_ind(input int i);
`ifdef STATUS_CODE_BLINK_EN
    return ((i / 4) % 2) == 0;
`else
    return (i >= 0);
`endif
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    check("reset_async", 3'b000, 4'd0);
    cycle();
    check("reset_held", 3'b000, 4'd0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("start_high_at_release", 3'b000, 4'd0);
    end

    //   s     w     l     c     code    cnt
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0, "drop_start");
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 4'd0, "idle_start");
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 4'd0, "start_held");
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 4'd0, "run_quiet");
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 4'd0, "start_in_run");
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 4'd0, "run_quiet2");
    add(1'b0, 1'b1, 1'b0, 1'b0, 3'b101, 4'd1, "run_win");
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 4'd1, "win_on");
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 4'd1, "win_start");
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 4'd1, "run_lose");
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 4'd1, "lose_on");
    add(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 4'd0, "lose_clear");
    add(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 4'd0, "win_in_idle");
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 4'd0, "idle_start2");
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'b111, 4'd0, "lose_beats_win");
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 4'd0, "lose_on2");
    add(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 4'd0, "clear_beats_start");
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0, "idle_quiet");
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 4'd0, "idle_start3");
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 4'd0, "run_quiet3");
    add(1'b0, 1'b1, 1'b0, 1'b0, 3'b101, 4'd1, "run_win2");
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'b101, 4'd1, "lose_in_win");
    add(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 4'd0, "win_clear");
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 4'd0, "idle_start4");

    foreach (vecs[i]) begin
      drive(vecs[i].s, vecs[i].w, vecs[i].l, vecs[i].c);
      cycle();
      check(vecs[i].name, vecs[i].code, vecs[i].cnt);
    end

    // Blink pattern after entering WIN, then async reset in the second off-phase.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    check("blink_0", 3'b101, 4'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 13; i++) begin
      cycle();
      check($sformatf("blink_%0d", i), {2'b10, blink_ind(i)}, 4'd1);
    end
    #3 rst_n = 1'b0;
    #1;
    check("reset_mid_blink", 3'b000, 4'd0);
    cycle();
    #3 rst_n = 1'b1;
    cycle();
    check("after_reset_idle", 3'b000, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    check("after_reset_start", 3'b011, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();

    // Win counter saturation across 17 rounds.
    for (int k = 1; k <= 17; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      cycle();
      check($sformatf("sat_win_%0d", k), 3'b101, (k > 15) ? 4'd15 : 4'(k));
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      check($sformatf("sat_run_%0d", k), 3'b011, (k > 15) ? 4'd15 : 4'(k));
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    check("sat_clear", 3'b000, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
